cr_huf_comp_min_bits_ctrl: RTL and testbench
============================================

Name: cr_huf_comp_min_bits_ctrl

Overview:
- Sequences the per-block encoding decision in the Huffman compressor.
- Collects the three candidate bit-count totals for one block (retrospective, predefined, simulated), which arrive independently and in any order.
- Once all enabled candidates are present, computes the minimum and its selector, then presents the decision to the encoder stage over a valid/ready handshake.
- Keeps saturating per-selection statistics counters for CSR readback.

Parameters:
- BITS_W, 20, width of each bit-count total and of min_num.
- TAG_W, 4, width of the block tag carried with each total.
- STAT_W, 32, width of each selection statistics counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ret_vld  in  1  retrospective total valid (single-cycle pulse)
- ret_bits  in  BITS_W  retrospective total
- ret_tag  in  TAG_W  block tag for ret
- pre_vld / pre_bits / pre_tag  in  1 / BITS_W / TAG_W  predefined total, same rules as ret
- sim_vld / sim_bits / sim_tag  in  1 / BITS_W / TAG_W  simulated total, same rules as ret
- sim_en  in  1  CSR: simulated candidate enabled; sampled only in IDLE
- force_sel  in  2  CSR: 0 = auto, 1 = force RET, 2 = force PRE, 3 = force SIM; sampled only in IDLE
- busy  out  1  block in progress (state != IDLE)
- dec_vld  out  1  decision valid
- dec_rdy  in  1  encoder accepts decision
- dec_min_num  out  BITS_W  bit count of the chosen encoding
- dec_min_sel  out  2  chosen encoding: RET = 0, PRE = 1, SIM = 2
- dec_tag  out  TAG_W  block tag
- tag_err  out  1  sticky: a tag mismatch or duplicate arrival was seen; cleared by rst only
- stat_ret_cnt / stat_pre_cnt / stat_sim_cnt  out  STAT_W each  saturating decision counters

Behaviour:
- Reset values: all outputs 0; state IDLE; all capture flags cleared. A rst asserted mid-block discards the block; no decision is emitted.
- States: IDLE, COLLECT, CMP, OUT.
- IDLE:
  - Latch sim_en and force_sel into shadow registers.
  - The first *_vld from any source captures that source's bits and tag, sets its flag, records the block tag, and moves to COLLECT.
  - If several *_vld arrive in the same cycle, all are captured; their tags must be equal.
- COLLECT:
  - Each *_vld captures bits and sets that source's flag.
  - A tag that differs from the block tag, or a vld on a source whose flag is already set, sets tag_err. That arrival is dropped; the captured value is unchanged.
  - sim_vld while sim_en is shadowed 0 is ignored; no error.
  - Leaves for CMP in the cycle after all required flags are set. Required flags are ret and pre, plus sim when sim_en = 1. This also applies when all inputs arrive in IDLE in the same cycle.
- CMP (exactly one cycle), auto mode:
  - sim disabled: sim is treated as all-ones.
  - Select RET if ret < pre and ret < sim (both strict).
  - Otherwise select PRE if pre < sim.
  - Otherwise select SIM. With sim disabled, a pre = sim = all-ones tie selects PRE.
  - Ties resolve as ret = pre → PRE and pre = sim → SIM.
- CMP, forced mode:
  - Selects the forced source and its bits.
  - Forcing SIM with sim disabled selects PRE instead and sets tag_err.
- CMP outputs: registers dec_min_num, dec_min_sel and dec_tag, then moves to OUT.
- OUT:
  - dec_vld = 1 and the dec_* outputs are held stable until dec_vld and dec_rdy are both high.
  - On handshake: increment the stat counter for the selected source (saturating at all-ones), clear flags, go to IDLE, and drop dec_vld the next cycle.
  - *_vld arrivals while in CMP or OUT set tag_err and are dropped. Upstream must wait for busy = 0.
- Latency: final required vld at cycle N gives dec_vld at cycle N+2, with dec_rdy tied high.
- Throughput: one decision per block. The earliest next capture is in the cycle after the handshake.
- All compares are unsigned at BITS_W width; there is no arithmetic overflow.

Test Plan:
- Auto, sim_en = 1, tag 3, in order pre = 500, sim = 450, ret = 400 on cycles 0, 2, 5 → dec_vld at cycle 7 with min_num 400, sel RET, tag 3; stat_ret_cnt = 1.
- Ties: ret = pre = 300, sim = 600 → PRE, 300. Next block: ret = 700, pre = sim = 200 → SIM, 200. dec_rdy held low 5 cycles: outputs stable throughout, one stat increment per block.
- sim_en = 0: ret = 900 and pre = 800 arrive in the same IDLE cycle, no sim → PRE, 800 at cycle +2. A later sim_vld during IDLE does not start a block and sets no error.
- force_sel = 1 with ret = 1000, pre = 10, sim = 20 → RET, 1000. force_sel = 3 with sim_en = 0 → PRE selected, tag_err = 1.
- Tag mismatch: ret tag 2, then pre tag 5 → tag_err = 1, pre dropped, block waits. pre tag 2 (plus sim tag 2) then completes normally. A duplicate ret_vld also sets tag_err.
- rst asserted in COLLECT and again in OUT → next cycle all outputs 0, IDLE, no dec_vld, stat counters 0. Stat counter preloaded to all-ones stays saturated after a further RET decision.

Source files
------------

// File: rtl/cr_huf_comp_min_bits_ctrl.sv
`timescale 1ns/1ps
// Per-block encoding decision for the Huffman compressor: collects the RET/PRE/SIM
// bit totals, picks the cheapest (or forced) encoding and hands it to the encoder.
module cr_huf_comp_min_bits_ctrl #(
  parameter int unsigned BITS_W = 20,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ret_vld,
  input  logic [BITS_W-1:0] ret_bits,
  input  logic [TAG_W-1:0]  ret_tag,
  input  logic              pre_vld,
  input  logic [BITS_W-1:0] pre_bits,
  input  logic [TAG_W-1:0]  pre_tag,
  input  logic              sim_vld,
  input  logic [BITS_W-1:0] sim_bits,
  input  logic [TAG_W-1:0]  sim_tag,
  input  logic              sim_en,
  input  logic [1:0]        force_sel,
  output logic              busy,
  output logic              dec_vld,
  input  logic              dec_rdy,
  output logic [BITS_W-1:0] dec_min_num,
  output logic [1:0]        dec_min_sel,
  output logic [TAG_W-1:0]  dec_tag,
  output logic              tag_err,
  output logic [STAT_W-1:0] stat_ret_cnt,
  output logic [STAT_W-1:0] stat_pre_cnt,
  output logic [STAT_W-1:0] stat_sim_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_CMP     = 2'd2;
  localparam logic [1:0] ST_OUT     = 2'd3;

  localparam logic [1:0] SEL_RET = 2'd0;
  localparam logic [1:0] SEL_PRE = 2'd1;
  localparam logic [1:0] SEL_SIM = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              sim_en_q, sim_en_d;
  logic [1:0]        force_q, force_d;
  logic [BITS_W-1:0] ret_bits_q, ret_bits_d;
  logic [BITS_W-1:0] pre_bits_q, pre_bits_d;
  logic [BITS_W-1:0] sim_bits_q, sim_bits_d;
  logic              ret_f_q, ret_f_d;
  logic              pre_f_q, pre_f_d;
  logic              sim_f_q, sim_f_d;
  logic [TAG_W-1:0]  blk_tag_q, blk_tag_d;
  logic              dec_vld_q, dec_vld_d;
  logic [BITS_W-1:0] dec_min_num_q, dec_min_num_d;
  logic [1:0]        dec_min_sel_q, dec_min_sel_d;
  logic [TAG_W-1:0]  dec_tag_q, dec_tag_d;
  logic              tag_err_q, tag_err_d;
  logic [STAT_W-1:0] stat_ret_cnt_q, stat_ret_cnt_d;
  logic [STAT_W-1:0] stat_pre_cnt_q, stat_pre_cnt_d;
  logic [STAT_W-1:0] stat_sim_cnt_q, stat_sim_cnt_d;

  logic              sim_en_eff;
  logic              sim_arr;
  logic              any_arr;
  logic [TAG_W-1:0]  first_tag;
  logic [TAG_W-1:0]  ref_tag;
  logic [BITS_W-1:0] sim_cand;
  logic [1:0]        sel;

  always_comb begin
    state_d        = state_q;
    sim_en_d       = sim_en_q;
    force_d        = force_q;
    ret_bits_d     = ret_bits_q;
    pre_bits_d     = pre_bits_q;
    sim_bits_d     = sim_bits_q;
    ret_f_d        = ret_f_q;
    pre_f_d        = pre_f_q;
    sim_f_d        = sim_f_q;
    blk_tag_d      = blk_tag_q;
    dec_vld_d      = dec_vld_q;
    dec_min_num_d  = dec_min_num_q;
    dec_min_sel_d  = dec_min_sel_q;
    dec_tag_d      = dec_tag_q;
    tag_err_d      = tag_err_q;
    stat_ret_cnt_d = stat_ret_cnt_q;
    stat_pre_cnt_d = stat_pre_cnt_q;
    stat_sim_cnt_d = stat_sim_cnt_q;
    sim_cand       = '1;
    sel            = SEL_PRE;

    // CSR values are live while idle and frozen in the shadows for the rest of the block
    sim_en_eff = (state_q == ST_IDLE) ? sim_en : sim_en_q;
    sim_arr    = sim_vld & sim_en_eff;
    any_arr    = ret_vld | pre_vld | sim_arr;
    first_tag  = ret_vld ? ret_tag : (pre_vld ? pre_tag : sim_tag);
    ref_tag    = (state_q == ST_IDLE) ? first_tag : blk_tag_q;

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (state_q == ST_IDLE) begin
          sim_en_d = sim_en;
          force_d  = force_sel;
        end
        if (ret_vld) begin
          if (ret_f_q || (ret_tag != ref_tag)) tag_err_d = 1'b1;
          else begin
            ret_bits_d = ret_bits;
            ret_f_d    = 1'b1;
          end
        end
        if (pre_vld) begin
          if (pre_f_q || (pre_tag != ref_tag)) tag_err_d = 1'b1;
          else begin
            pre_bits_d = pre_bits;
            pre_f_d    = 1'b1;
          end
        end
        if (sim_arr) begin
          if (sim_f_q || (sim_tag != ref_tag)) tag_err_d = 1'b1;
          else begin
            sim_bits_d = sim_bits;
            sim_f_d    = 1'b1;
          end
        end
        if ((state_q == ST_IDLE) && any_arr) begin
          blk_tag_d = first_tag;
          state_d   = ST_COLLECT;
        end
        // Completion is judged on the post-capture flags so the final arrival goes straight to CMP
        if (ret_f_d && pre_f_d && (sim_f_d || !sim_en_eff)) state_d = ST_CMP;
      end
      ST_CMP: begin
        if (any_arr) tag_err_d = 1'b1;
        sim_cand = sim_en_q ? sim_bits_q : '1;
        case (force_q)
          2'd1: sel = SEL_RET;
          2'd2: sel = SEL_PRE;
          2'd3: begin
            sel = sim_en_q ? SEL_SIM : SEL_PRE;
            if (!sim_en_q) tag_err_d = 1'b1;
          end
          default: begin
            if ((ret_bits_q < pre_bits_q) && (ret_bits_q < sim_cand)) sel = SEL_RET;
            else if ((pre_bits_q < sim_cand) || !sim_en_q)            sel = SEL_PRE;
            else                                                       sel = SEL_SIM;
          end
        endcase
        dec_min_sel_d = sel;
        dec_min_num_d = (sel == SEL_RET) ? ret_bits_q :
                        (sel == SEL_PRE) ? pre_bits_q : sim_bits_q;
        dec_tag_d     = blk_tag_q;
        dec_vld_d     = 1'b1;
        state_d       = ST_OUT;
      end
      default: begin
        if (any_arr) tag_err_d = 1'b1;
        if (dec_rdy) begin
          case (dec_min_sel_q)
            SEL_RET: if (stat_ret_cnt_q != '1) stat_ret_cnt_d = stat_ret_cnt_q + STAT_W'(1);
            SEL_PRE: if (stat_pre_cnt_q != '1) stat_pre_cnt_d = stat_pre_cnt_q + STAT_W'(1);
            default: if (stat_sim_cnt_q != '1) stat_sim_cnt_d = stat_sim_cnt_q + STAT_W'(1);
          endcase
          ret_f_d   = 1'b0;
          pre_f_d   = 1'b0;
          sim_f_d   = 1'b0;
          dec_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      sim_en_q       <= 1'b0;
      force_q        <= '0;
      ret_bits_q     <= '0;
      pre_bits_q     <= '0;
      sim_bits_q     <= '0;
      ret_f_q        <= 1'b0;
      pre_f_q        <= 1'b0;
      sim_f_q        <= 1'b0;
      blk_tag_q      <= '0;
      dec_vld_q      <= 1'b0;
      dec_min_num_q  <= '0;
      dec_min_sel_q  <= '0;
      dec_tag_q      <= '0;
      tag_err_q      <= 1'b0;
      stat_ret_cnt_q <= '0;
      stat_pre_cnt_q <= '0;
      stat_sim_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      sim_en_q       <= sim_en_d;
      force_q        <= force_d;
      ret_bits_q     <= ret_bits_d;
      pre_bits_q     <= pre_bits_d;
      sim_bits_q     <= sim_bits_d;
      ret_f_q        <= ret_f_d;
      pre_f_q        <= pre_f_d;
      sim_f_q        <= sim_f_d;
      blk_tag_q      <= blk_tag_d;
      dec_vld_q      <= dec_vld_d;
      dec_min_num_q  <= dec_min_num_d;
      dec_min_sel_q  <= dec_min_sel_d;
      dec_tag_q      <= dec_tag_d;
      tag_err_q      <= tag_err_d;
      stat_ret_cnt_q <= stat_ret_cnt_d;
      stat_pre_cnt_q <= stat_pre_cnt_d;
      stat_sim_cnt_q <= stat_sim_cnt_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign dec_vld      = dec_vld_q;
  assign dec_min_num  = dec_min_num_q;
  assign dec_min_sel  = dec_min_sel_q;
  assign dec_tag      = dec_tag_q;
  assign tag_err      = tag_err_q;
  assign stat_ret_cnt = stat_ret_cnt_q;
  assign stat_pre_cnt = stat_pre_cnt_q;
  assign stat_sim_cnt = stat_sim_cnt_q;

endmodule

// File: tb/tb_cr_huf_comp_min_bits_ctrl.sv
`timescale 1ns/1ps
// Bench for cr_huf_comp_min_bits_ctrl: directed scenarios plus randomized blocks
// checked against a min-with-tie-to-latest reference model.
module tb_cr_huf_comp_min_bits_ctrl;

  localparam int unsigned STAT_MAX = 15;

  logic        clk;
  logic        rst;
  logic        ret_vld, pre_vld, sim_vld;
  logic [19:0] ret_bits, pre_bits, sim_bits;
  logic [3:0]  ret_tag, pre_tag, sim_tag;
  logic        sim_en;
  logic [1:0]  force_sel;
  logic        busy, dec_vld, dec_rdy, tag_err;
  logic [19:0] dec_min_num;
  logic [1:0]  dec_min_sel;
  logic [3:0]  dec_tag;
  logic [3:0]  stat_ret_cnt, stat_pre_cnt, stat_sim_cnt;

  int unsigned checks;
  int unsigned failures;
  int unsigned cnt [3];
  logic        exp_err;

  cr_huf_comp_min_bits_ctrl #(.BITS_W(20), .TAG_W(4), .STAT_W(4)) dut (
    .clk(clk), .rst(rst),
    .ret_vld(ret_vld), .ret_bits(ret_bits), .ret_tag(ret_tag),
    .pre_vld(pre_vld), .pre_bits(pre_bits), .pre_tag(pre_tag),
    .sim_vld(sim_vld), .sim_bits(sim_bits), .sim_tag(sim_tag),
    .sim_en(sim_en), .force_sel(force_sel), .busy(busy),
    .dec_vld(dec_vld), .dec_rdy(dec_rdy), .dec_min_num(dec_min_num),
    .dec_min_sel(dec_min_sel), .dec_tag(dec_tag), .tag_err(tag_err),
    .stat_ret_cnt(stat_ret_cnt), .stat_pre_cnt(stat_pre_cnt), .stat_sim_cnt(stat_sim_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
    end
  endtask

  // Smallest total wins; on equal totals the later candidate (RET, PRE, SIM order) wins.
  function automatic logic [1:0] model_sel(input logic [19:0] r, input logic [19:0] p,
                                           input logic [19:0] s, input logic en,
                                           input logic [1:0] f);
    logic [19:0] vals [3];
    int unsigned best;
    int unsigned n;
    vals[0] = r;
    vals[1] = p;
    vals[2] = s;
    if (f != 2'd0) return (f == 2'd3 && !en) ? 2'd1 : f - 2'd1;
    n    = en ? 3 : 2;
    best = 0;
    for (int unsigned i = 1; i < n; i++)
      if (vals[i] <= vals[best]) best = i;
    return 2'(best);
  endfunction

  task automatic drive(input logic r, input logic [19:0] rb, input logic [3:0] rt,
                       input logic p, input logic [19:0] pb, input logic [3:0] pt,
                       input logic s, input logic [19:0] sb, input logic [3:0] st);
    ret_vld = r; ret_bits = rb; ret_tag = rt;
    pre_vld = p; pre_bits = pb; pre_tag = pt;
    sim_vld = s; sim_bits = sb; sim_tag = st;
    tick();
    ret_vld = 1'b0; pre_vld = 1'b0; sim_vld = 1'b0;
  endtask

  task automatic chk_stats(input string nm);
    chk({nm, ".stat_ret"}, 32'(stat_ret_cnt), cnt[0]);
    chk({nm, ".stat_pre"}, 32'(stat_pre_cnt), cnt[1]);
    chk({nm, ".stat_sim"}, 32'(stat_sim_cnt), cnt[2]);
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
    exp_err = 1'b0;
    chk({nm, ".busy"},    32'(busy), 0);
    chk({nm, ".dec_vld"}, 32'(dec_vld), 0);
    chk({nm, ".num"},     32'(dec_min_num), 0);
    chk({nm, ".sel"},     32'(dec_min_sel), 0);
    chk({nm, ".tag"},     32'(dec_tag), 0);
    chk({nm, ".tag_err"}, 32'(tag_err), 0);
    chk_stats(nm);
  endtask

  // Entered right after the edge that sampled the final required arrival.
  task automatic expect_dec(input string nm, input logic [19:0] num, input logic [1:0] sel,
                            input logic [3:0] tag, input int unsigned stall);
    chk({nm, ".cmp_vld"},  32'(dec_vld), 0);
    chk({nm, ".cmp_busy"}, 32'(busy), 1);
    tick();
    chk({nm, ".vld"}, 32'(dec_vld), 1);
    chk({nm, ".num"}, 32'(dec_min_num), 32'(num));
    chk({nm, ".sel"}, 32'(dec_min_sel), 32'(sel));
    chk({nm, ".tag"}, 32'(dec_tag), 32'(tag));
    for (int unsigned i = 0; i < stall; i++) begin
      tick();
      chk({nm, ".hold_vld"}, 32'(dec_vld), 1);
      chk({nm, ".hold_num"}, 32'(dec_min_num), 32'(num));
      chk({nm, ".hold_sel"}, 32'(dec_min_sel), 32'(sel));
      chk({nm, ".hold_tag"}, 32'(dec_tag), 32'(tag));
    end
    dec_rdy = 1'b1;
    tick();
    dec_rdy = 1'b0;
    if (cnt[sel] < STAT_MAX) cnt[sel]++;
    chk({nm, ".post_vld"},  32'(dec_vld), 0);
    chk({nm, ".post_busy"}, 32'(busy), 0);
    chk({nm, ".tag_err"},   32'(tag_err), 32'(exp_err));
    chk_stats(nm);
  endtask

  task automatic rand_block();
    logic [19:0] v [3];
    logic [3:0]  tg;
    logic        en;
    logic [1:0]  f;
    logic [1:0]  s;
    int unsigned off [3];
    int unsigned last;
    int unsigned nsrc;
    en = 1'($urandom_range(0, 1));
    f  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    tg = 4'($urandom);
    for (int i = 0; i < 3; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i] = 20'($urandom_range(0, 3));
        1:       v[i] = '1;
        default: v[i] = 20'($urandom);
      endcase
    end
    sim_en    = en;
    force_sel = f;
    nsrc      = en ? 3 : 2;
    last      = 0;
    off[2]    = 99;
    for (int unsigned i = 0; i < nsrc; i++) begin
      off[i] = $urandom_range(0, 3);
      if (off[i] > last) last = off[i];
    end
    for (int unsigned t = 0; t <= last; t++)
      drive(off[0] == t, v[0], tg, off[1] == t, v[1], tg, en && (off[2] == t), v[2], tg);
    s = model_sel(v[0], v[1], v[2], en, f);
    if (f == 2'd3 && !en) exp_err = 1'b1;
    expect_dec("rand", v[s], s, tg, $urandom_range(0, 2));
  endtask

  initial begin
    checks = 0; failures = 0; exp_err = 1'b0;
    rst = 1'b1; dec_rdy = 1'b0; sim_en = 1'b1; force_sel = 2'd0;
    ret_vld = 1'b0; pre_vld = 1'b0; sim_vld = 1'b0;
    ret_bits = '0; pre_bits = '0; sim_bits = '0;
    ret_tag = '0; pre_tag = '0; sim_tag = '0;
    tick();
    do_reset("reset");

    // Out-of-order arrival: pre@0, sim@2, ret@5 -> decision visible at cycle 7
    drive(0, 0, 0, 1, 500, 3, 0, 0, 0);
    chk("order.busy", 32'(busy), 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 450, 3);
    tick();
    tick();
    chk("order.wait_vld", 32'(dec_vld), 0);
    drive(1, 400, 3, 0, 0, 0, 0, 0, 0);
    expect_dec("order", 400, 2'd0, 3, 0);

    // Ties with a stalled consumer
    drive(1, 300, 6, 1, 300, 6, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 600, 6);
    expect_dec("tie_rp", 300, 2'd1, 6, 5);
    drive(1, 700, 7, 1, 200, 7, 1, 200, 7);
    expect_dec("tie_ps", 200, 2'd2, 7, 5);

    // Sim disabled: both present in the same idle cycle
    sim_en = 1'b0;
    drive(1, 900, 1, 1, 800, 1, 0, 0, 0);
    expect_dec("nosim", 800, 2'd1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 5, 1);
    chk("nosim_sim.busy",    32'(busy), 0);
    chk("nosim_sim.tag_err", 32'(tag_err), 0);
    tick();
    chk("nosim_sim.vld",     32'(dec_vld), 0);

    // Forced modes; force_sel changes mid-block must not matter
    sim_en = 1'b1; force_sel = 2'd1;
    drive(1, 1000, 4, 0, 0, 0, 0, 0, 0);
    force_sel = 2'd0;
    drive(0, 0, 0, 1, 10, 4, 1, 20, 4);
    expect_dec("force_ret", 1000, 2'd0, 4, 0);
    sim_en = 1'b0; force_sel = 2'd3;
    drive(1, 50, 2, 1, 60, 2, 0, 0, 0);
    exp_err = 1'b1;
    expect_dec("force_sim_off", 60, 2'd1, 2, 0);

    // Tag mismatch drops the arrival and the block keeps waiting
    sim_en = 1'b1; force_sel = 2'd0;
    do_reset("rst2");
    drive(1, 50, 2, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 10, 5, 0, 0, 0);
    chk("tagmm.tag_err", 32'(tag_err), 1);
    tick();
    chk("tagmm.wait_vld",  32'(dec_vld), 0);
    chk("tagmm.wait_busy", 32'(busy), 1);
    drive(0, 0, 0, 1, 100, 2, 1, 120, 2);
    exp_err = 1'b1;
    expect_dec("tagmm", 50, 2'd0, 2, 0);

    // Duplicate arrival keeps the first captured value
    do_reset("rst3");
    drive(1, 30, 1, 0, 0, 0, 0, 0, 0);
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0);
    chk("dup.tag_err", 32'(tag_err), 1);
    drive(0, 0, 0, 1, 40, 1, 1, 50, 1);
    exp_err = 1'b1;
    expect_dec("dup", 30, 2'd0, 1, 0);

    // Reset in COLLECT and in OUT discards the block
    do_reset("rst4");
    drive(1, 8, 9, 1, 9, 9, 1, 9, 9);
    expect_dec("pre_rst", 8, 2'd0, 9, 0);
    drive(1, 8, 9, 0, 0, 0, 0, 0, 0);
    chk("collect.busy", 32'(busy), 1);
    do_reset("rst_collect");
    tick();
    chk("rst_collect.later_vld", 32'(dec_vld), 0);
    drive(1, 5, 9, 1, 6, 9, 1, 7, 9);
    tick();
    chk("out.vld", 32'(dec_vld), 1);
    do_reset("rst_out");
    tick();
    chk("rst_out.later_vld", 32'(dec_vld), 0);

    // Drive the RET counter past its maximum
    sim_en = 1'b0; force_sel = 2'd1;
    for (int unsigned i = 0; i < STAT_MAX + 2; i++) begin
      drive(1, 20'(i + 100), 4'(i), 1, 0, 4'(i), 0, 0, 0);
      expect_dec("sat", 20'(i + 100), 2'd0, 4'(i), 0);
    end
    chk("sat.final", 32'(stat_ret_cnt), STAT_MAX);

    force_sel = 2'd0;
    for (int unsigned i = 0; i < 80; i++) rand_block();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
